conv_adder_tree_acc: RTL and testbench

Parametrised, pipelined signed adder tree with an optional multi-beat channel accumulator, for the convolution stages. It sums N_IN sign-extended partial products per beat through registered pairwise levels, then accumulates consecutive beats (input channels) between `in_first` and `in_last` markers into one result. It generalises the fixed three-input single-cycle adder stage and feeds the activation/pooling stage.

---
 rtl/conv_adder_tree_acc_pkg.sv | 26 ++
 rtl/conv_adder_tree_acc_if.sv | 21 ++
 rtl/conv_adder_tree_level.sv | 34 +++
 rtl/conv_adder_tree_acc.sv | 129 ++++++++++++
 tb/tb_conv_adder_tree_acc.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/conv_adder_tree_acc_pkg.sv
// Shared constants, width helpers and accumulator FSM encoding for the
// convolution adder tree / channel accumulator.
package conv_adder_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // operand count after k pairwise levels: ceil(n / 2^k)
  function automatic int lvl_n(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  localparam int N_IN_DEF      = 3;
  localparam int IN_W_DEF      = 19;
  localparam int ACC_EXTRA_DEF = 4;
  localparam int D             = clog2(N_IN_DEF);
  localparam int SUM_W         = IN_W_DEF + D;
  localparam int ACC_W         = SUM_W + ACC_EXTRA_DEF;

  typedef enum logic {IDLE, ACCUM} acc_state_e;

endpackage

// File: rtl/conv_adder_tree_acc_if.sv
// Beat / result bus between the convolution datapath and the adder tree.
interface conv_adder_tree_acc_if
  import conv_adder_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int ACC_WI = ACC_W
);
  logic                   in_valid;
  logic                   in_first;
  logic                   in_last;
  logic [N_IN*IN_W-1:0]   in_data;
  logic                   out_valid;
  logic [ACC_WI-1:0]      out_data;
  logic                   out_overflow;

  modport master (output in_valid, in_first, in_last, in_data,
                  input  out_valid, out_data, out_overflow);
  modport slave  (input  in_valid, in_first, in_last, in_data,
                  output out_valid, out_data, out_overflow);
endinterface

// File: rtl/conv_adder_tree_level.sv
// One registered pairwise-add level: adjacent operands are sign-extended by
// one bit and summed; an odd trailing operand is sign-extended and passed on.
module conv_adder_tree_level #(
  parameter  int N  = 3,
  parameter  int W  = 19,
  localparam int NO = (N + 1) / 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N*W-1:0]     i_data,
  output logic [NO*(W+1)-1:0] o_data
);

  logic [NO*(W+1)-1:0] w_nxt;

  for (genvar j = 0; j < NO; j++) begin : g_pair
    logic [W-1:0] w_a;
    assign w_a = i_data[2*j*W +: W];
    if (2*j + 1 < N) begin : g_add
      logic [W-1:0] w_b;
      assign w_b = i_data[(2*j+1)*W +: W];
      assign w_nxt[j*(W+1) +: W+1] = {w_a[W-1], w_a} + {w_b[W-1], w_b};
    end else begin : g_pass
      assign w_nxt[j*(W+1) +: W+1] = {w_a[W-1], w_a};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       o_data <= '0;
    else if (enable) o_data <= w_nxt;
  end

endmodule

// File: rtl/conv_adder_tree_acc.sv
// Pipelined signed adder tree plus multi-beat channel accumulator.
// Optional build macro CONV_ADDER_RELU_EN clamps negative emitted results to 0.
module conv_adder_tree_acc
  import conv_adder_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_EXTRA = ACC_EXTRA_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  conv_adder_tree_acc_if.slave   bus
);

  localparam int TD     = clog2(N_IN);
  localparam int TSUM_W = IN_W + TD;
  localparam int TACC_W = TSUM_W + ACC_EXTRA;

  // ---- tree levels
  for (genvar k = 0; k < TD; k++) begin : g_lvl
    localparam int NI = lvl_n(N_IN, k);
    localparam int WI = IN_W + k;
    localparam int NO = lvl_n(N_IN, k + 1);
    logic [NI*WI-1:0]     w_in;
    logic [NO*(WI+1)-1:0] w_out;
    if (k == 0) begin : g_src
      assign w_in = bus.in_data;
    end else begin : g_src
      assign w_in = g_lvl[k-1].w_out;
    end
    conv_adder_tree_level #(.N(NI), .W(WI)) u_lvl (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .i_data (w_in),
      .o_data (w_out)
    );
  end

  logic [TSUM_W-1:0] w_sum;
  assign w_sum = g_lvl[TD-1].w_out;

  // ---- sideband, aligned with the tree output at bit TD-1
  logic [TD-1:0] r_vld_pipe, r_first_pipe, r_last_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe   <= '0;
      r_first_pipe <= '0;
      r_last_pipe  <= '0;
    end else if (enable) begin
      r_vld_pipe   <= TD'({r_vld_pipe,   bus.in_valid});
      r_first_pipe <= TD'({r_first_pipe, bus.in_first});
      r_last_pipe  <= TD'({r_last_pipe,  bus.in_last});
    end
  end

  logic w_beat, w_first, w_last;
  assign w_beat  = r_vld_pipe[TD-1];
  assign w_first = r_first_pipe[TD-1];
  assign w_last  = r_last_pipe[TD-1];

  // ---- accumulator and FSM
  acc_state_e               r_state, w_state_nxt;
  logic signed [TACC_W-1:0] r_acc, w_acc_nxt, w_sext, w_add;
  logic                     r_sticky, w_sticky_nxt, w_add_ovf, w_emit;
  logic                     r_out_valid, r_out_ovf;
  logic [TACC_W-1:0]        r_out_data, w_out_nxt;

  assign w_sext    = TACC_W'($signed(w_sum));
  assign w_add     = r_acc + w_sext;
  assign w_add_ovf = (r_acc[TACC_W-1] == w_sext[TACC_W-1]) &&
                     (w_add[TACC_W-1] != r_acc[TACC_W-1]);

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_sticky_nxt = r_sticky;
    w_emit       = 1'b0;
    if (w_beat) begin
      // a beat arriving in IDLE always opens a fresh group
      if (r_state == IDLE || w_first) begin
        w_acc_nxt    = w_sext;
        w_sticky_nxt = 1'b0;
      end else begin
        w_acc_nxt    = w_add;
        w_sticky_nxt = r_sticky | w_add_ovf;
      end
      if (w_last) begin
        w_emit      = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = ACCUM;
      end
    end
  end

`ifdef CONV_ADDER_RELU_EN
  assign w_out_nxt = w_acc_nxt[TACC_W-1] ? '0 : w_acc_nxt;
`else
  assign w_out_nxt = w_acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (enable) begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_sticky    <= w_sticky_nxt;
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data <= w_out_nxt;
        r_out_ovf  <= w_sticky_nxt;
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_overflow = r_out_ovf;

endmodule

// File: tb/tb_conv_adder_tree_acc.sv
// Directed bench for conv_adder_tree_acc at N_IN=3, IN_W=19, ACC_W=25.
module tb_conv_adder_tree_acc;

  logic clk = 1'b0;
  logic reset, enable;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  conv_adder_tree_acc_if bus ();

  conv_adder_tree_acc dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // result monitor: a result counts when presented on an advancing cycle
  int                 n_out = 0;
  int                 o_cyc = 0;
  logic signed [24:0] o_data = '0;
  logic               o_ovf = 1'b0;

  always @(negedge clk) begin
    if (!reset && enable && bus.out_valid) begin
      n_out  = n_out + 1;
      o_cyc  = cyc;
      o_data = $signed(bus.out_data);
      o_ovf  = bus.out_overflow;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic signed [18:0] a, b, c, input logic f, l);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_last  = l;
    bus.in_data  = {c, b, a};
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_out(input int n0, input string tag);
    int k;
    k = 0;
    while (n_out == n0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_seen"}, longint'(n_out > n0), 1);
  endtask

  int n0, t0;
  longint exp_neg, exp_wrap;

  initial begin
`ifdef CONV_ADDER_RELU_EN
    exp_neg  = 0;
    exp_wrap = 0;
`else
    exp_neg  = -786432;
    exp_wrap = 17301438 - 33554432;
`endif
    reset = 1'b1; enable = 1'b1;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", $signed(bus.out_data), 0);
    chk("rst_ovf", bus.out_overflow, 0);

    // single beat, three-cycle latency
    n0 = n_out;
    beat(100, -50, 7, 1, 1); t0 = cyc;
    idle();
    wait_out(n0, "t1");
    chk("t1_data", o_data, 57);
    chk("t1_ovf", o_ovf, 0);
    chk("t1_lat", o_cyc - t0, 3);

    // most negative operands, no loss in the tree width
    n0 = n_out;
    beat(-262144, -262144, -262144, 1, 1);
    idle();
    wait_out(n0, "t2");
    chk("t2_data", o_data, exp_neg);
    chk("t2_ovf", o_ovf, 0);

    // four-beat group, no early output
    n0 = n_out;
    for (int i = 0; i < 4; i++) beat(1000, 1000, 1000, i == 0, i == 3);
    @(negedge clk);
    chk("t3_early", n_out, n0);
    idle();
    wait_out(n0, "t3");
    chk("t3_data", o_data, 12000);
    repeat (6) @(negedge clk);
    chk("t3_count", n_out, n0 + 1);

    // 22 beats of max operands wrap the 25-bit accumulator
    n0 = n_out;
    for (int i = 0; i < 22; i++) beat(262143, 262143, 262143, i == 0, i == 21);
    idle();
    wait_out(n0, "t4");
    chk("t4_data", o_data, exp_wrap);
    chk("t4_ovf", o_ovf, 1);

    // restart drops the partial group: (1+2+3) + (4+4+4)
    n0 = n_out;
    beat(10, 10, 10, 1, 0);
    beat(20, 20, 20, 0, 0);
    beat(1, 2, 3, 1, 0);
    beat(4, 4, 4, 0, 1);
    idle();
    wait_out(n0, "t5");
    chk("t5_data", o_data, 18);
    chk("t5_ovf", o_ovf, 0);
    repeat (6) @(negedge clk);
    chk("t5_count", n_out, n0 + 1);

    // 5-cycle stall right after the last beat is sampled
    n0 = n_out;
    beat(5, 5, 5, 1, 0);
    beat(5, 5, 5, 0, 1); t0 = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    wait_out(n0, "t6");
    chk("t6_data", o_data, 30);
    chk("t6_lat", o_cyc - t0, 8);

    // reset with the closing beat in flight
    n0 = n_out;
    beat(1, 1, 1, 1, 0);
    beat(1, 1, 1, 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_valid", bus.out_valid, 0);
    chk("t7_data", $signed(bus.out_data), 0);
    chk("t7_ovf", bus.out_overflow, 0);
    repeat (6) @(negedge clk);
    chk("t7_count", n_out, n0);

    // last without first from IDLE behaves as a single-beat group
    n0 = n_out;
    beat(2, 2, 2, 0, 1);
    idle();
    wait_out(n0, "t8");
    chk("t8_data", o_data, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
